// File: rtl/ptw_cache_pkg.sv
// Shared definitions for the PTW response cache: default geometry and
// helpers for deriving index widths from the parameters.
package ptw_cache_pkg;

   localparam int DEFAULT_ENTRIES  = 8;
   localparam int DEFAULT_CHANNELS = 2;
   localparam int DEFAULT_VPN_W    = 20;
   localparam int DEFAULT_PPN_W    = 32;

   // Victim pointer and entry index width.
   function automatic int ptr_width(input int entries);
      return (entries > 1) ? $clog2(entries) : 1;
   endfunction

   // Channel index width; a single channel still needs a 1-bit index.
   function automatic int chan_width(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/ptw_fill_arbiter.sv
// Fixed-priority arbiter: lowest-indexed requesting channel wins.
module ptw_fill_arbiter #(
   parameter int CHANNELS = 2,
   parameter int IDX_W    = 1
) (
   input  logic [CHANNELS-1:0] req,
   output logic [CHANNELS-1:0] grant,
   output logic [IDX_W-1:0]    index,
   output logic                any
);

   // Scan from the top so the lowest requester is written last and wins.
   always_comb begin
      grant = '0;
      index = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            index    = IDX_W'(i);
         end
      end
      any = |req;
   end

endmodule

// File: rtl/ptw_resp_cache.sv
// Fully-associative translation cache filled by PTW responses from several
// channels; answers VPN lookups with a registered hit/error/PPN response.
module ptw_resp_cache
   import ptw_cache_pkg::*;
#(
   parameter int ENTRIES  = DEFAULT_ENTRIES,
   parameter int CHANNELS = DEFAULT_CHANNELS,
   parameter int VPN_W    = DEFAULT_VPN_W,
   parameter int PPN_W    = DEFAULT_PPN_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      io_flush,
   input  logic [CHANNELS-1:0]       io_fill_valid,
   output logic [CHANNELS-1:0]       io_fill_ready,
   input  logic [CHANNELS*VPN_W-1:0] io_fill_bits_vpn,
   input  logic [CHANNELS*PPN_W-1:0] io_fill_bits_ppn,
   input  logic [CHANNELS-1:0]       io_fill_bits_error,
   input  logic                      io_req_valid,
   output logic                      io_req_ready,
   input  logic [VPN_W-1:0]          io_req_bits_vpn,
   output logic                      io_resp_valid,
   output logic                      io_resp_bits_hit,
   output logic                      io_resp_bits_error,
   output logic [PPN_W-1:0]          io_resp_bits_ppn
);

   localparam int PTR_W = ptr_width(ENTRIES);
   localparam int CH_W  = chan_width(CHANNELS);

   typedef struct packed {
      logic             hit;
      logic             error;
      logic [PPN_W-1:0] ppn;
   } resp_t;

   logic [ENTRIES-1:0] valid;
   logic [VPN_W-1:0]   vpn_q   [ENTRIES];
   logic [PPN_W-1:0]   ppn_q   [ENTRIES];
   logic               error_q [ENTRIES];
   logic [PTR_W-1:0]   victim_ptr;
   resp_t              resp_q;
   logic               resp_valid_q;

   logic [CHANNELS-1:0] grant;
   logic [CH_W-1:0]     grant_idx;
   logic                grant_any;

   ptw_fill_arbiter #(
      .CHANNELS (CHANNELS),
      .IDX_W    (CH_W)
   ) u_arb (
      .req   (io_fill_valid),
      .grant (grant),
      .index (grant_idx),
      .any   (grant_any)
   );

   logic             fill_fire;
   logic [VPN_W-1:0] fill_vpn;
   logic [PPN_W-1:0] fill_ppn;
   logic             fill_error;

   assign io_fill_ready = (reset || io_flush) ? '0 : grant;
   assign fill_fire     = grant_any && !reset && !io_flush;
   assign fill_vpn      = io_fill_bits_vpn[grant_idx*VPN_W +: VPN_W];
   assign fill_ppn      = io_fill_bits_ppn[grant_idx*PPN_W +: PPN_W];
   assign fill_error    = io_fill_bits_error[grant_idx];
   assign io_req_ready  = 1'b1;

   logic             found_match;
   logic             found_free;
   logic [PTR_W-1:0] match_idx;
   logic [PTR_W-1:0] free_idx;
   logic [PTR_W-1:0] place_idx;
   logic             use_victim;

   // Placement priority: matching valid entry, then lowest free, then victim.
   always_comb begin
      found_match = 1'b0;
      found_free  = 1'b0;
      match_idx   = '0;
      free_idx    = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (valid[i] && vpn_q[i] == fill_vpn) begin
            found_match = 1'b1;
            match_idx   = PTR_W'(i);
         end
         if (!valid[i]) begin
            found_free = 1'b1;
            free_idx   = PTR_W'(i);
         end
      end
      use_victim = !found_match && !found_free;
      if (found_match)     place_idx = match_idx;
      else if (found_free) place_idx = free_idx;
      else                 place_idx = victim_ptr;
   end

   logic             lk_hit;
   logic             lk_error;
   logic [PPN_W-1:0] lk_ppn;

   // At most one valid entry can match, so OR-reducing the hits is safe.
   always_comb begin
      lk_hit   = 1'b0;
      lk_error = 1'b0;
      lk_ppn   = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid[i] && vpn_q[i] == io_req_bits_vpn) begin
            lk_hit   = 1'b1;
            lk_error = lk_error | error_q[i];
            lk_ppn   = lk_ppn | ppn_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid        <= '0;
         victim_ptr   <= '0;
         resp_valid_q <= 1'b0;
         resp_q       <= '0;
      end else begin
         resp_valid_q <= io_req_valid;
         resp_q.hit   <= lk_hit && !io_flush;
         resp_q.error <= lk_hit && !io_flush && lk_error;
         resp_q.ppn   <= (lk_hit && !io_flush && !lk_error) ? lk_ppn : '0;
         if (io_flush) begin
            valid      <= '0;
            victim_ptr <= '0;
         end else if (fill_fire) begin
            valid[place_idx] <= 1'b1;
            if (use_victim) victim_ptr <= victim_ptr + PTR_W'(1);
         end
      end
   end

   // Entry payload is qualified by the valid bits, so it needs no reset.
   always_ff @(posedge clk) begin
      if (fill_fire) begin
         vpn_q[place_idx]   <= fill_vpn;
         ppn_q[place_idx]   <= fill_ppn;
         error_q[place_idx] <= fill_error;
      end
   end

   assign io_resp_valid      = resp_valid_q;
   assign io_resp_bits_hit   = resp_q.hit;
   assign io_resp_bits_error = resp_q.error;
   assign io_resp_bits_ppn   = resp_q.ppn;

endmodule

// File: tb/tb_ptw_resp_cache.sv
// Randomized and directed bench for ptw_resp_cache against a behavioural model.
module tb_ptw_resp_cache;

   localparam int ENTRIES  = 8;
   localparam int CHANNELS = 2;
   localparam int VPN_W    = 20;
   localparam int PPN_W    = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                      reset;
   logic                      io_flush;
   logic [CHANNELS-1:0]       io_fill_valid;
   logic [CHANNELS-1:0]       io_fill_ready;
   logic [CHANNELS*VPN_W-1:0] io_fill_bits_vpn;
   logic [CHANNELS*PPN_W-1:0] io_fill_bits_ppn;
   logic [CHANNELS-1:0]       io_fill_bits_error;
   logic                      io_req_valid;
   logic                      io_req_ready;
   logic [VPN_W-1:0]          io_req_bits_vpn;
   logic                      io_resp_valid;
   logic                      io_resp_bits_hit;
   logic                      io_resp_bits_error;
   logic [PPN_W-1:0]          io_resp_bits_ppn;

   ptw_resp_cache #(
      .ENTRIES  (ENTRIES),
      .CHANNELS (CHANNELS),
      .VPN_W    (VPN_W),
      .PPN_W    (PPN_W)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .io_flush           (io_flush),
      .io_fill_valid      (io_fill_valid),
      .io_fill_ready      (io_fill_ready),
      .io_fill_bits_vpn   (io_fill_bits_vpn),
      .io_fill_bits_ppn   (io_fill_bits_ppn),
      .io_fill_bits_error (io_fill_bits_error),
      .io_req_valid       (io_req_valid),
      .io_req_ready       (io_req_ready),
      .io_req_bits_vpn    (io_req_bits_vpn),
      .io_resp_valid      (io_resp_valid),
      .io_resp_bits_hit   (io_resp_bits_hit),
      .io_resp_bits_error (io_resp_bits_error),
      .io_resp_bits_ppn   (io_resp_bits_ppn)
   );

   int errors = 0;
   int checks = 0;

   // Reference contents: a plain table of translations plus a replacement cursor.
   bit          m_valid [ENTRIES];
   logic [19:0] m_vpn   [ENTRIES];
   logic [31:0] m_ppn   [ENTRIES];
   bit          m_err   [ENTRIES];
   int          m_ptr;

   logic        exp_rv;
   logic        exp_hit;
   logic        exp_err;
   logic [31:0] exp_ppn;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic int modelFind(input logic [19:0] v);
      for (int i = 0; i < ENTRIES; i++)
         if (m_valid[i] && m_vpn[i] == v) return i;
      return -1;
   endfunction

   task automatic modelClear();
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      m_ptr = 0;
   endtask

   task automatic modelFill(input logic [19:0] v, input logic [31:0] p, input bit e);
      int k;
      k = modelFind(v);
      if (k < 0) begin
         for (int i = ENTRIES - 1; i >= 0; i--)
            if (!m_valid[i]) k = i;
      end
      if (k < 0) begin
         k = m_ptr;
         m_ptr = (m_ptr + 1) % ENTRIES;
      end
      m_valid[k] = 1'b1;
      m_vpn[k]   = v;
      m_ppn[k]   = p;
      m_err[k]   = e;
   endtask

   // One full clock cycle: drive, check ready, advance model, check response.
   task automatic applyStimulus(input logic rst, input logic fl, input logic [1:0] fv,
                                input logic [19:0] v0, input logic [19:0] v1,
                                input logic [31:0] p0, input logic [31:0] p1,
                                input logic [1:0] fe, input logic rq, input logic [19:0] rv);
      logic [1:0] er;
      int k;
      reset              = rst;
      io_flush           = fl;
      io_fill_valid      = fv;
      io_fill_bits_vpn   = {v1, v0};
      io_fill_bits_ppn   = {p1, p0};
      io_fill_bits_error = fe;
      io_req_valid       = rq;
      io_req_bits_vpn    = rv;
      #1;
      if (rst || fl)  er = 2'b00;
      else if (fv[0]) er = 2'b01;
      else if (fv[1]) er = 2'b10;
      else            er = 2'b00;
      checkOutput("fill_ready", 64'(io_fill_ready), 64'(er));
      checkOutput("req_ready", 64'(io_req_ready), 64'd1);

      exp_rv  = rq && !rst;
      exp_hit = 1'b0;
      exp_err = 1'b0;
      exp_ppn = '0;
      if (rst) begin
         modelClear();
      end else begin
         k = fl ? -1 : modelFind(rv);
         if (k >= 0) begin
            exp_hit = 1'b1;
            exp_err = m_err[k];
            exp_ppn = m_err[k] ? 32'd0 : m_ppn[k];
         end
         if (fl)               modelClear();
         else if (er == 2'b01) modelFill(v0, p0, fe[0]);
         else if (er == 2'b10) modelFill(v1, p1, fe[1]);
      end

      @(posedge clk);
      #1;
      checkOutput("resp_valid", 64'(io_resp_valid), 64'(exp_rv));
      if (exp_rv) begin
         checkOutput("resp_hit", 64'(io_resp_bits_hit), 64'(exp_hit));
         checkOutput("resp_error", 64'(io_resp_bits_error), 64'(exp_err));
         checkOutput("resp_ppn", 64'(io_resp_bits_ppn), 64'(exp_ppn));
      end
   endtask

   task automatic fillCh0(input logic [19:0] v, input logic [31:0] p, input logic e);
      applyStimulus(1'b0, 1'b0, 2'b01, v, 20'd0, p, 32'd0, {1'b0, e}, 1'b0, 20'd0);
   endtask

   task automatic lookup(input logic [19:0] v);
      applyStimulus(1'b0, 1'b0, 2'b00, 20'd0, 20'd0, 32'd0, 32'd0, 2'b00, 1'b1, v);
   endtask

   initial begin
      modelClear();
      // Reset with fills and a request pending: nothing accepted, nothing answered.
      applyStimulus(1'b1, 1'b0, 2'b11, 20'h1, 20'h2, 32'h1, 32'h2, 2'b00, 1'b1, 20'h1);
      applyStimulus(1'b1, 1'b1, 2'b00, 20'h0, 20'h0, 32'h0, 32'h0, 2'b00, 1'b0, 20'h0);

      lookup(20'h00010);
      checkOutput("tp_reset_miss", 64'(io_resp_bits_hit), 64'd0);

      fillCh0(20'h00010, 32'hDEAD0000, 1'b0);
      lookup(20'h00010);
      checkOutput("tp_fill_ppn", 64'(io_resp_bits_ppn), 64'hDEAD0000);

      applyStimulus(1'b0, 1'b0, 2'b11, 20'h1, 20'h2, 32'h11, 32'h22, 2'b00, 1'b0, 20'h0);
      applyStimulus(1'b0, 1'b0, 2'b10, 20'h1, 20'h2, 32'h11, 32'h22, 2'b00, 1'b1, 20'h2);
      lookup(20'h1);
      lookup(20'h2);
      checkOutput("tp_ch1_ppn", 64'(io_resp_bits_ppn), 64'h22);

      // Nine distinct VPNs into eight entries forces one victim replacement.
      applyStimulus(1'b0, 1'b1, 2'b00, 20'h0, 20'h0, 32'h0, 32'h0, 2'b00, 1'b0, 20'h0);
      for (int i = 1; i <= 9; i++) fillCh0(20'(i), 32'(i * 16'h100), 1'b0);
      for (int i = 1; i <= 9; i++) lookup(20'(i));
      fillCh0(20'h5, 32'h55, 1'b0);
      for (int i = 1; i <= 9; i++) lookup(20'(i));
      lookup(20'h5);
      checkOutput("tp_refill_ppn", 64'(io_resp_bits_ppn), 64'h55);

      fillCh0(20'h7, 32'h777, 1'b1);
      lookup(20'h7);
      checkOutput("tp_err_ppn", 64'(io_resp_bits_ppn), 64'd0);
      checkOutput("tp_err_flag", 64'(io_resp_bits_error), 64'd1);

      // Flush with concurrent fill and lookup.
      applyStimulus(1'b0, 1'b1, 2'b11, 20'h3, 20'h4, 32'h3, 32'h4, 2'b00, 1'b1, 20'h2);
      checkOutput("tp_flush_hit", 64'(io_resp_bits_hit), 64'd0);
      for (int i = 1; i <= 9; i++) lookup(20'(i));

      // Back-to-back requests, then reset landing on a pending request.
      fillCh0(20'h3, 32'h333, 1'b0);
      lookup(20'h3);
      lookup(20'h3);
      applyStimulus(1'b1, 1'b0, 2'b00, 20'h0, 20'h0, 32'h0, 32'h0, 2'b00, 1'b1, 20'h3);
      checkOutput("tp_reset_drop", 64'(io_resp_valid), 64'd0);
      lookup(20'h3);

      for (int n = 0; n < 800; n++) begin
         logic        rst;
         logic        fl;
         logic [1:0]  fv;
         logic [1:0]  fe;
         logic        rq;
         rst = ($urandom_range(0, 99) == 0);
         fl  = ($urandom_range(0, 24) == 0);
         fv  = 2'($urandom_range(0, 3));
         fe  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         rq  = ($urandom_range(0, 3) != 0);
         applyStimulus(rst, fl, fv, 20'($urandom_range(0, 15)), 20'($urandom_range(0, 15)),
                       $urandom, $urandom, fe, rq, 20'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
